// File: rtl/bp_update_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bp_pkg
// Description : Shared types and default sizes for the branch update queue.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int BHT_IDX_BITS = 10;
    localparam int BPQ_DEPTH    = 16;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } bpq_state_t;

    typedef struct packed {
        bpq_state_t                state;
        logic [BHT_IDX_BITS-1:0]   bht_idx;
        logic                      pred_taken;
        logic                      act_taken;
    } bpq_entry_t;

endpackage
`default_nettype wire

// File: rtl/bp_update_queue_if.sv
`default_nettype none
// ============================================================================
// Interface   : bp_update_queue_if
// Description : Allocate / resolve / flush / update bundle of the branch queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface bp_update_queue_if #(
    parameter int DEPTH        = bp_pkg::BPQ_DEPTH,
    parameter int BHT_IDX_BITS = bp_pkg::BHT_IDX_BITS
);
    localparam int TAG_BITS = $clog2(DEPTH);

    logic                    alloc_valid;
    logic                    alloc_ready;
    logic [BHT_IDX_BITS-1:0] alloc_bht_idx;
    logic                    alloc_pred_taken;
    logic [TAG_BITS-1:0]     alloc_tag;
    logic                    resolve_valid;
    logic [TAG_BITS-1:0]     resolve_tag;
    logic                    resolve_taken;
    logic                    mispredict_valid;
    logic [TAG_BITS-1:0]     mispredict_tag;
    logic                    flush_valid;
    logic [TAG_BITS-1:0]     flush_tag;
    logic                    flush_all;
    logic                    update_valid;
    logic [BHT_IDX_BITS-1:0] update_bht_idx;
    logic                    update_taken;

    modport master (
        output alloc_valid, alloc_bht_idx, alloc_pred_taken,
        output resolve_valid, resolve_tag, resolve_taken,
        output flush_valid, flush_tag, flush_all,
        input  alloc_ready, alloc_tag, mispredict_valid, mispredict_tag,
        input  update_valid, update_bht_idx, update_taken
    );

    modport slave (
        input  alloc_valid, alloc_bht_idx, alloc_pred_taken,
        input  resolve_valid, resolve_tag, resolve_taken,
        input  flush_valid, flush_tag, flush_all,
        output alloc_ready, alloc_tag, mispredict_valid, mispredict_tag,
        output update_valid, update_bht_idx, update_taken
    );

endinterface
`default_nettype wire

// File: rtl/bp_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : bp_update_queue
// Description : In-order retire queue feeding gshare updates; out-of-order
//               resolve, mispredict report, partial/full flush. rst is
//               asynchronous active-low. Optional macro BPQ_STATS_EN adds
//               saturating retire/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_update_queue #(
    parameter int DEPTH        = bp_pkg::BPQ_DEPTH,
    parameter int BHT_IDX_BITS = bp_pkg::BHT_IDX_BITS
) (
    input  wire                clk,
    input  wire                rst,
    bp_update_queue_if.slave   bus
`ifdef BPQ_STATS_EN
    ,
    output logic [31:0]        stat_retired,
    output logic [31:0]        stat_mispredicts
`endif
);
    import bp_pkg::*;

    localparam int TAG_BITS = $clog2(DEPTH);

    bpq_entry_t              r_entry [DEPTH];
    logic [TAG_BITS:0]       r_head;
    logic [TAG_BITS:0]       r_tail;
    logic                    r_mp_valid;
    logic [TAG_BITS-1:0]     r_mp_tag;

    logic [TAG_BITS-1:0]     w_head_idx;
    logic [TAG_BITS-1:0]     w_tail_idx;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_alloc;
    logic                    w_retire;
    logic                    w_resolve;
    logic                    w_resolve_mis;
    logic [TAG_BITS-1:0]     w_age_flush;
    logic [TAG_BITS:0]       w_flush_tail;
    logic [DEPTH-1:0]        w_squash;
    logic [BHT_IDX_BITS-1:0] w_upd_idx;

    assign w_head_idx = r_head[TAG_BITS-1:0];
    assign w_tail_idx = r_tail[TAG_BITS-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[TAG_BITS] != r_tail[TAG_BITS]);

    assign bus.alloc_ready = !w_full && !bus.flush_valid && !bus.flush_all;
    assign bus.alloc_tag   = w_tail_idx;
    assign w_alloc         = bus.alloc_valid && bus.alloc_ready;

    assign w_retire           = !w_empty && (r_entry[w_head_idx].state == RESOLVED);
    assign w_upd_idx          = r_entry[w_head_idx].bht_idx;
    assign bus.update_valid   = w_retire;
    assign bus.update_bht_idx = w_upd_idx;
    assign bus.update_taken   = r_entry[w_head_idx].act_taken;

    // Age relative to head; anything older than the flush point survives.
    assign w_age_flush  = bus.flush_tag - w_head_idx;
    assign w_flush_tail = r_head + (TAG_BITS+1)'(w_age_flush) + (TAG_BITS+1)'(1);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
        logic [TAG_BITS-1:0] w_age;
        assign w_age        = TAG_BITS'(gi) - w_head_idx;
        assign w_squash[gi] = bus.flush_valid && (w_age > w_age_flush);
    end

    assign w_resolve     = bus.resolve_valid && !bus.flush_all && !w_squash[bus.resolve_tag]
                           && (r_entry[bus.resolve_tag].state == PENDING);
    assign w_resolve_mis = w_resolve && (bus.resolve_taken != r_entry[bus.resolve_tag].pred_taken);

    assign bus.mispredict_valid = r_mp_valid;
    assign bus.mispredict_tag   = r_mp_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_mp_valid <= 1'b0;
            r_mp_tag   <= '0;
        end else if (bus.flush_all) begin
            for (int i = 0; i < DEPTH; i++) r_entry[i].state <= FREE;
            r_tail     <= r_head;
            r_mp_valid <= 1'b0;
        end else begin
            if (w_retire) begin
                r_entry[w_head_idx].state <= FREE;
                r_head                    <= r_head + (TAG_BITS+1)'(1);
            end
            if (w_resolve) begin
                r_entry[bus.resolve_tag].state     <= RESOLVED;
                r_entry[bus.resolve_tag].act_taken <= bus.resolve_taken;
            end
            r_mp_valid <= w_resolve_mis;
            if (w_resolve_mis) r_mp_tag <= bus.resolve_tag;
            if (w_alloc) begin
                r_entry[w_tail_idx] <= '{state: PENDING, bht_idx: bus.alloc_bht_idx,
                                         pred_taken: bus.alloc_pred_taken, act_taken: 1'b0};
                r_tail              <= r_tail + (TAG_BITS+1)'(1);
            end
            // Squash runs last; alloc is blocked during flush so no slot conflict.
            if (bus.flush_valid) begin
                r_tail <= w_flush_tail;
                for (int i = 0; i < DEPTH; i++)
                    if (w_squash[i]) r_entry[i].state <= FREE;
            end
        end
    end

`ifdef BPQ_STATS_EN
    logic [31:0] r_stat_retired;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_retired     <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_retire) begin
            if (r_stat_retired != '1) r_stat_retired <= r_stat_retired + 32'd1;
            if ((r_entry[w_head_idx].act_taken != r_entry[w_head_idx].pred_taken)
                && (r_stat_mispredicts != '1))
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_retired     = r_stat_retired;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
`default_nettype wire

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- Sits between fetch/execute and gshare_predictor's update port.
- At fetch, stores each conditional branch's BHT index and predicted direction; execute then resolves branches out of order.
- Branches retire in program order, driving exactly one predictor update per branch (update_valid / update_bht_idx / update_taken).
- Reports mispredicts to the flush logic and discards wrong-path entries on flush.

Parameters:
- DEPTH, 16, number of in-flight branch entries (power of two, >=2).
- BHT_IDX_BITS, 10, width of stored BHT index (matches predictor).
- TAG_BITS, $clog2(DEPTH), localparam; entry tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (queue reset while rst==0).
- alloc_valid  in  1  fetch presents a new branch.
- alloc_ready  out  1  queue can accept (not full, no flush this cycle).
- alloc_bht_idx  in  BHT_IDX_BITS  index from predictor bht_idx_out.
- alloc_pred_taken  in  1  predictor's predict_taken.
- alloc_tag  out  TAG_BITS  tag assigned to the allocating branch (= tail slot).
- resolve_valid  in  1  execute resolved a branch.
- resolve_tag  in  TAG_BITS  tag of resolved branch.
- resolve_taken  in  1  actual direction.
- mispredict_valid  out  1  registered pulse, resolved direction != predicted.
- mispredict_tag  out  TAG_BITS  tag of mispredicted branch.
- flush_valid  in  1  squash all entries strictly younger than flush_tag.
- flush_tag  in  TAG_BITS  oldest surviving (mispredicted) entry.
- flush_all  in  1  squash every entry (exception/redirect).
- update_valid  out  1  to predictor update_valid.
- update_bht_idx  out  BHT_IDX_BITS  to predictor update_bht_idx.
- update_taken  out  1  to predictor update_taken.

Behaviour:
- Storage and pointers:
  - Per-entry state is FREE, PENDING or RESOLVED, plus bht_idx, pred_taken and act_taken.
  - head/tail are TAG_BITS+1 wide (wrap bit).
  - empty when head==tail; full when the indices are equal and the wrap bits differ.
- Reset (rst==0, async): all entries FREE; head=tail=0; mispredict_valid=0, mispredict_tag=0; update_valid=0; update_bht_idx=0; update_taken=0.
- Allocate:
  - Accepted when alloc_valid && alloc_ready.
  - Entry at tail becomes PENDING; tail advances.
  - alloc_tag is combinational from tail.
  - alloc_ready = !full && !flush_valid && !flush_all.
- Resolve:
  - Applies only if the entry at resolve_tag is PENDING; it becomes RESOLVED and stores act_taken.
  - Resolves to FREE or RESOLVED entries are ignored.
  - mispredict_valid/mispredict_tag are registered, valid 1 cycle after the resolve, only when act_taken != pred_taken.
- Retire:
  - update_valid = head entry RESOLVED && !empty (combinational from registered state).
  - update_bht_idx/update_taken come from the head entry; update_taken = act_taken.
  - When update_valid is high, head advances at the clock edge and the entry becomes FREE. At most one retire per cycle.
  - Resolving the head in cycle N produces update_valid in cycle N+1.
- Flush:
  - Age is measured as (tag - head[TAG_BITS-1:0]) mod DEPTH.
  - Entries with age > age(flush_tag) become FREE; tail = flush_tag+1 (with the correct wrap bit).
  - The flush_tag entry and older entries are untouched.
- flush_all: every entry FREE; tail=head; pending mispredict output cleared next cycle.
- Simultaneous events:
  - flush_all overrides everything.
  - A flush in the same cycle as a resolve targeting a squashed entry means the resolve is ignored and no mispredict is reported.
  - Retire and flush in the same cycle both occur; head advances.
  - A resolve and a retire of a different entry in the same cycle both occur.
  - A resolve of the head entry updates state only; its retire follows in the next cycle.
- Reset asserted mid-operation drops all entries with no update pulse.

Optional Feature:
- BPQ_STATS_EN: adds 32-bit output ports stat_retired and stat_mispredicts.
  - stat_retired increments on every update_valid.
  - stat_mispredicts increments on retire when act_taken != pred_taken.
  - Both saturate at 2^32-1, reset to 0, and are not cleared by flush.
- Without the macro: no ports and no counters.

Decomposition:
- Shared package bp_pkg holds:
  - the enum bpq_state_t {FREE, PENDING, RESOLVED};
  - the struct bpq_entry_t {state, bht_idx, pred_taken, act_taken};
  - the default constants BHT_IDX_BITS=10 and BPQ_DEPTH=16.
- Single module; no sub-module is warranted. Stats counters are inline under the macro.

Test Plan:
- Allocate idx 0x005 pred=1 (tag 0), resolve tag0 taken=1 -> cycle+1: update_valid=1, idx=0x005, taken=1; mispredict_valid stays 0.
- Allocate tags 0,1,2; resolve 2 then 1 then 0 -> no update until tag0 resolves, then updates for tags 0,1,2 in consecutive cycles, in order.
- Allocate 16 -> alloc_ready=0; 17th alloc_valid is not accepted; retire one -> alloc_ready=1 next cycle.
- Allocate tags 0-4, resolve tag1 with pred=1, actual=0 -> mispredict_valid=1, tag=1 next cycle; flush_tag=1 -> tags 2-4 FREE, next alloc_tag=2; retire order is 0, 1.
- Head/tail wrapped (head=14): flush with tag 15 while resolve targets tag 0 -> resolve ignored, tail=0, no mispredict.
- Assert rst=0 asynchronously with 5 PENDING entries -> outputs 0 immediately, empty after release, first alloc_tag=0.
